product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator_pkg.sv | 14 +
 rtl/acc_adder.sv | 13 +
 rtl/product_accumulator.sv | 82 ++++++++
 tb/tb_product_accumulator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared multiplier-path definitions: default widths and the accumulator FSM encoding.
package product_accumulator_pkg;

  localparam int unsigned PROD_W = 32;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_adder.sv
// Pure combinational W-bit adder returning the carry out of the top bit.
module acc_adder #(
  parameter int unsigned W = 40
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/product_accumulator.sv
// Sums a run of len unsigned products into a wrapping accumulator with a sticky
// overflow flag, then holds the result until the downstream consumer takes it.
module product_accumulator #(
  parameter int unsigned PROD_W = product_accumulator_pkg::PROD_W,
  parameter int unsigned ACC_W  = product_accumulator_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  import product_accumulator_pkg::*;

  state_t            r_state;
  state_t            w_next_state;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic [LEN_W-1:0]  r_count;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  w_sum;
  logic              w_carry;
  logic              w_beat;
  logic              w_start_acc;

  assign w_prod_ext  = ACC_W'(prod_in);
  assign w_beat      = (r_state == ACCUM) && prod_valid;
  assign w_start_acc = (r_state == IDLE) && start;

  acc_adder #(.W(ACC_W)) u_adder (
    .i_a     (r_acc),
    .i_b     (w_prod_ext),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (prod_valid && (r_count == LEN_W'(1))) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A zero-length start clears acc/ovf too, so DONE reports 0 without a beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (w_start_acc) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= len;
    end else if (w_beat) begin
      r_acc   <= w_sum;
      r_ovf   <= r_ovf | w_carry;
      r_count <= r_count - LEN_W'(1);
    end
  end

  assign prod_ready = (r_state == ACCUM);
  assign out_valid  = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign acc_out    = r_acc;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed checks of product_accumulator against a sum-of-products model.
module tb_product_accumulator;

  localparam int unsigned PW  = 32;
  localparam int unsigned AW  = 40;
  localparam int unsigned AW2 = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, prod_valid, out_ready, prod_ready, ovf, out_valid, busy;
  logic [7:0]    len;
  logic [PW-1:0] prod_in;
  logic [AW-1:0] acc_out;

  logic           b_start, b_prod_valid, b_out_ready, b_prod_ready, b_ovf, b_out_valid, b_busy;
  logic [7:0]     b_len;
  logic [PW-1:0]  b_prod_in;
  logic [AW2-1:0] b_acc_out;

  int checks = 0;
  int errors = 0;

  product_accumulator #(.PROD_W(PW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  product_accumulator #(.PROD_W(PW), .ACC_W(AW2)) dut_narrow (
    .clk(clk), .rst(rst), .start(b_start), .len(b_len), .prod_in(b_prod_in),
    .prod_valid(b_prod_valid), .prod_ready(b_prod_ready), .acc_out(b_acc_out),
    .ovf(b_ovf), .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy)
  );

  // Reference: the run result is the plain sum; it wraps and flags when it reaches 2^width.
  function automatic logic [63:0] model_sum(input logic [31:0] q[$]);
    logic [63:0] s = '0;
    foreach (q[i]) s += 64'(q[i]);
    return s;
  endfunction

  function automatic logic [63:0] wrap(input logic [63:0] s, input int unsigned w);
    return s & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic over(input logic [63:0] s, input int unsigned w);
    return (s >> w) != 64'd0;
  endfunction

  // Stimulus helpers: entered and left on a falling edge.
  task automatic start_run(input logic [7:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0; len = 8'($urandom);
  endtask

  task automatic beat(input logic [31:0] p);
    prod_valid = 1'b1; prod_in = p;
    @(negedge clk);
    prod_valid = 1'b0; prod_in = $urandom;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic b_start_run(input logic [7:0] l);
    b_start = 1'b1; b_len = l;
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic b_beat(input logic [31:0] p);
    b_prod_valid = 1'b1; b_prod_in = p;
    @(negedge clk);
    b_prod_valid = 1'b0;
  endtask

  task automatic b_consume();
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, out_valid, prod_ready, ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, out_valid, prod_ready, ovf});
    end
    checks++;
    if (acc_out !== '0) begin errors++; $display("FAIL reset_acc got=%h exp=0", acc_out); end
    checks++;
    if ({b_busy, b_out_valid, b_prod_ready, b_ovf} !== 4'b0000 || b_acc_out !== '0) begin
      errors++; $display("FAIL reset_narrow got=%b/%h exp=0000/0",
                         {b_busy, b_out_valid, b_prod_ready, b_ovf}, b_acc_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] q[$] = '{32'd10, 32'd20, 32'd30};
    logic [63:0] s = model_sum(q);
    start_run(8'd3);
    checks++;
    if ({busy, prod_ready, out_valid} !== 3'b110) begin
      errors++; $display("FAIL basic_accum_state got=%b exp=110", {busy, prod_ready, out_valid});
    end
    beat(q[0]);
    beat(q[1]);
    checks++;
    if (out_valid !== 1'b0 || acc_out !== AW'(30)) begin
      errors++; $display("FAIL basic_partial got=%b/%0d exp=0/30", out_valid, acc_out);
    end
    beat(q[2]);
    checks++;
    if (out_valid !== 1'b1 || prod_ready !== 1'b0) begin
      errors++; $display("FAIL basic_latency got=%b%b exp=10", out_valid, prod_ready);
    end
    checks++;
    if (acc_out !== AW'(wrap(s, AW)) || ovf !== over(s, AW)) begin
      errors++; $display("FAIL basic_result got=%0d/%b exp=%0d/%b", acc_out, ovf, wrap(s, AW), over(s, AW));
    end
    consume();
    checks++;
    if ({busy, out_valid} !== 2'b00 || acc_out !== AW'(wrap(s, AW))) begin
      errors++; $display("FAIL basic_idle_hold got=%b/%0d exp=00/%0d", {busy, out_valid}, acc_out, wrap(s, AW));
    end
  endtask

  task automatic test_gaps();
    start_run(8'd2);
    beat(32'd5);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin start = 1'b1; len = 8'd1; end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (acc_out !== AW'(5) || prod_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL gap_hold[%0d] got=%0d/%b%b exp=5/10", i, acc_out, prod_ready, out_valid);
      end
    end
    beat(32'd7);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== AW'(12)) begin
      errors++; $display("FAIL gap_result got=%b/%0d exp=1/12", out_valid, acc_out);
    end
    consume();
  endtask

  task automatic test_max_len();
    logic [63:0] s = 64'd255 * 64'hFFFF_FFFF;
    start_run(8'd255);
    for (int i = 0; i < 255; i++) beat(32'hFFFF_FFFF);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== AW'(wrap(s, AW)) || ovf !== over(s, AW)) begin
      errors++; $display("FAIL max_len got=%b/%h/%b exp=1/%h/%b", out_valid, acc_out, ovf, wrap(s, AW), over(s, AW));
    end
    consume();
  endtask

  task automatic test_overflow();
    int unsigned n_list[3] = '{2, 3, 1};
    logic [31:0] q[$];
    logic [63:0] s;
    for (int r = 0; r < 3; r++) begin
      q.delete();
      for (int unsigned i = 0; i < n_list[r]; i++) q.push_back((r == 2) ? 32'd1 : 32'hFFFF_FFFF);
      s = model_sum(q);
      b_start_run(8'(n_list[r]));
      foreach (q[i]) b_beat(q[i]);
      checks++;
      if (b_out_valid !== 1'b1 || b_acc_out !== AW2'(wrap(s, AW2)) || b_ovf !== over(s, AW2)) begin
        errors++; $display("FAIL narrow_run[%0d] got=%b/%h/%b exp=1/%h/%b",
                           r, b_out_valid, b_acc_out, b_ovf, wrap(s, AW2), over(s, AW2));
      end
      b_consume();
      checks++;
      if (b_ovf !== over(s, AW2) || b_busy !== 1'b0) begin
        errors++; $display("FAIL narrow_sticky[%0d] got=%b/%b exp=%b/0", r, b_ovf, b_busy, over(s, AW2));
      end
    end
  endtask

  task automatic test_len_zero();
    start_run(8'd0);
    checks++;
    if ({out_valid, busy, prod_ready, ovf} !== 4'b1100 || acc_out !== '0) begin
      errors++; $display("FAIL zero_len got=%b/%h exp=1100/0", {out_valid, busy, prod_ready, ovf}, acc_out);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; len = 8'd9; end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || acc_out !== '0 || ovf !== 1'b0) begin
        errors++; $display("FAIL zero_stable[%0d] got=%b/%h/%b exp=1/0/0", i, out_valid, acc_out, ovf);
      end
    end
    out_ready = 1'b1; start = 1'b1; len = 8'd4;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, out_valid, prod_ready} !== 3'b000) begin
      errors++; $display("FAIL done_start_ignored got=%b exp=000", {busy, out_valid, prod_ready});
    end
  endtask

  task automatic test_reset_mid();
    start_run(8'd4);
    beat(32'd100);
    beat(32'd200);
    rst = 1'b1; prod_valid = 1'b1; prod_in = 32'd50;
    @(negedge clk);
    checks++;
    if ({busy, out_valid, prod_ready, ovf} !== 4'b0000 || acc_out !== '0) begin
      errors++; $display("FAIL mid_reset got=%b/%h exp=0000/0", {busy, out_valid, prod_ready, ovf}, acc_out);
    end
    rst = 1'b0; prod_valid = 1'b0;
    @(negedge clk);
    start_run(8'd1);
    beat(32'd7);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== AW'(7)) begin
      errors++; $display("FAIL after_reset_run got=%b/%0d exp=1/7", out_valid, acc_out);
    end
    consume();
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [63:0] s;
    int unsigned n;
    for (int r = 0; r < 20; r++) begin
      q.delete();
      n = $urandom_range(1, 24);
      for (int unsigned i = 0; i < n; i++) q.push_back($urandom);
      s = model_sum(q);
      start_run(8'(n));
      foreach (q[i]) begin
        repeat ($urandom_range(0, 2)) begin
          start = ($urandom_range(0, 3) == 0); len = 8'($urandom);
          @(negedge clk);
          start = 1'b0;
        end
        beat(q[i]);
      end
      checks++;
      if (out_valid !== 1'b1 || acc_out !== AW'(wrap(s, AW)) || ovf !== over(s, AW)) begin
        errors++; $display("FAIL rand_wide[%0d] got=%b/%h/%b exp=1/%h/%b",
                           r, out_valid, acc_out, ovf, wrap(s, AW), over(s, AW));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      consume();

      q.delete();
      n = $urandom_range(1, 5);
      for (int unsigned i = 0; i < n; i++) q.push_back($urandom | 32'hC000_0000);
      s = model_sum(q);
      b_start_run(8'(n));
      foreach (q[i]) b_beat(q[i]);
      checks++;
      if (b_out_valid !== 1'b1 || b_acc_out !== AW2'(wrap(s, AW2)) || b_ovf !== over(s, AW2)) begin
        errors++; $display("FAIL rand_narrow[%0d] got=%b/%h/%b exp=1/%h/%b",
                           r, b_out_valid, b_acc_out, b_ovf, wrap(s, AW2), over(s, AW2));
      end
      b_consume();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; len = '0; prod_in = '0; prod_valid = 1'b0; out_ready = 1'b0;
    b_start = 1'b0; b_len = '0; b_prod_in = '0; b_prod_valid = 1'b0; b_out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_max_len();
    test_overflow();
    test_len_zero();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
